// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, operand widths and the divider state encoding.
package alu_pkg;

    localparam int unsigned DW = 10;
    localparam int unsigned VW = 5;

    localparam logic [5:0] OP_MUL = 6'b000100;
    localparam logic [5:0] OP_DIV = 6'b000101;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } div_state_e;

endpackage

// File: rtl/division_unit_even_parity.sv
// Balance flag: high when the operand holds an even number of ones (zero counts as even).
module even_parity
    import alu_pkg::*;
(
    input  logic [DW-1:0] data_i,
    output logic          even_o
);

    assign even_o = ~(^data_i);

endmodule

// File: rtl/division_unit.sv
// Sequential unsigned restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per cycle.
module division_unit
    import alu_pkg::*;
#(
    parameter logic [5:0] OPCODE = OP_DIV
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] Number1,
    input  logic [VW-1:0] Number2,
    input  logic [5:0]    printout,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          divzero,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          balancebit,
    output logic [31:0]   conclusion
);

    localparam int unsigned CW = $clog2(DW);

    div_state_e    state_q;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    logic [DW-1:0] dvd_q;
    logic [VW-1:0] dvs_q;
    logic [VW-1:0] prem_q;
    logic [CW-1:0] cnt_q;

    logic          busy_q;
    logic          done_q;
    logic          divzero_q;
    logic          bal_q;
    logic [DW-1:0] quo_q;
    logic [VW-1:0] rem_q;

    logic [VW:0]   shifted_c;
    logic [VW:0]   diff_c;
    logic          qbit_c;
    logic [VW-1:0] prem_d;
    logic [DW-1:0] dvd_d;

    logic [DW-1:0] res_quo_c;
    logic [VW-1:0] res_rem_c;
    logic          res_even_c;

    // One restoring step; the extra top bit of the working value exposes the borrow.
    always_comb begin
        shifted_c = {1'b0, prem_q[VW-1:0]} << 1;
        shifted_c[0] = dvd_q[DW-1];
        diff_c    = shifted_c - {1'b0, dvs_q};
        qbit_c    = ~diff_c[VW];
        prem_d    = qbit_c ? diff_c[VW-1:0] : shifted_c[VW-1:0];
        dvd_d     = {dvd_q[DW-2:0], qbit_c};
    end

    // Result selection: the last RUN step, or the fixed divide-by-zero answer.
    always_comb begin
        res_quo_c = {DW{1'b1}};
        res_rem_c = '0;
        if (state_q == RUN) begin
            res_quo_c = dvd_d;
            res_rem_c = prem_d;
        end
    end

    even_parity u_parity (
        .data_i (res_quo_c),
        .even_o (res_even_c)
    );

    // Control FSM, operand/iteration registers and registered results.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            prem_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
            bal_q     <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && (printout == OPCODE)) begin
                        dvd_q   <= Number1;
                        dvs_q   <= Number2;
                        prem_q  <= '0;
                        cnt_q   <= CW'(DW - 1);
                        busy_q  <= 1'b1;
                        state_q <= (Number2 == '0) ? FIN : RUN;
                    end
                end
                RUN: begin
                    dvd_q  <= dvd_d;
                    prem_q <= prem_d;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        quo_q     <= res_quo_c;
                        rem_q     <= res_rem_c;
                        bal_q     <= res_even_c;
                        divzero_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= FIN;
                    end
                end
                FIN: begin
                    // Entered with done already raised after RUN; the zero-divisor path raises it here.
                    if (done_q) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        quo_q     <= res_quo_c;
                        rem_q     <= res_rem_c;
                        bal_q     <= res_even_c;
                        divzero_q <= 1'b1;
                        done_q    <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign divzero    = divzero_q;
    assign quotient   = quo_q;
    assign remainder  = rem_q;
    assign balancebit = bal_q;
    assign conclusion = {{(32 - DW){1'b0}}, quo_q};

endmodule

// File: tb/tb_division_unit.sv
// Self-checking bench for division_unit: directed cases plus randomized traffic against a reference model.
module tb_division_unit;
    import alu_pkg::*;

    logic          clk;
    logic          reset;
    logic [DW-1:0] Number1;
    logic [VW-1:0] Number2;
    logic [5:0]    printout;
    logic          start;
    logic          busy;
    logic          done;
    logic          divzero;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          balancebit;
    logic [31:0]   conclusion;

    int vectors = 0;
    int miscompares = 0;

    division_unit dut (
        .clk        (clk),
        .reset      (reset),
        .Number1    (Number1),
        .Number2    (Number2),
        .printout   (printout),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .divzero    (divzero),
        .quotient   (quotient),
        .remainder  (remainder),
        .balancebit (balancebit),
        .conclusion (conclusion)
    );

    always #5 clk = ~clk;

    // Reference model state: what the outputs must show after each rising edge.
    int            edge_n    = 0;
    int            done_edge = -1;
    int            accepted  = 0;
    bit            synced    = 0;
    logic          m_busy    = 0;
    logic          m_done    = 0;
    logic          m_dz      = 0;
    logic          m_bal     = 0;
    logic [DW-1:0] m_q       = '0;
    logic [VW-1:0] m_r       = '0;
    logic [DW-1:0] p_q       = '0;
    logic [VW-1:0] p_r       = '0;
    logic          p_dz      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Model: a request is honoured once the previous one has fully drained; the answer is plain / and %.
    always @(posedge clk) begin
        edge_n++;
        if (reset) begin
            synced    = 1;
            done_edge = -1;
            m_busy    = 0;
            m_done    = 0;
            m_dz      = 0;
            m_bal     = 0;
            m_q       = '0;
            m_r       = '0;
        end else begin
            m_done = (done_edge >= 0) && (edge_n == done_edge);
            if (m_done) begin
                m_q   = p_q;
                m_r   = p_r;
                m_dz  = p_dz;
                m_bal = ($countones(p_q) % 2) == 0;
            end
            m_busy = (done_edge >= 0) && (edge_n <= done_edge);
            if (start && printout == OP_DIV && !((done_edge >= 0) && (edge_n <= done_edge + 1))) begin
                accepted++;
                if (Number2 == 0) begin
                    p_q       = 10'h3FF;
                    p_r       = '0;
                    p_dz      = 1;
                    done_edge = edge_n + 1;
                end else begin
                    p_q       = DW'(int'(Number1) / int'(Number2));
                    p_r       = VW'(int'(Number1) % int'(Number2));
                    p_dz      = 0;
                    done_edge = edge_n + 10;
                end
                m_busy = 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (synced) begin
            chk("busy",       32'(busy),       32'(m_busy));
            chk("done",       32'(done),       32'(m_done));
            chk("divzero",    32'(divzero),    32'(m_dz));
            chk("quotient",   32'(quotient),   32'(m_q));
            chk("remainder",  32'(remainder),  32'(m_r));
            chk("balancebit", 32'(balancebit), 32'(m_bal));
            chk("conclusion", conclusion,      {22'b0, m_q});
        end
    end

    // Directed division with hand-computed expectations, including done latency after acceptance.
    task automatic run_div(input logic [DW-1:0] n1, input logic [VW-1:0] n2, input int exp_lat,
                           input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic eb, input logic edz);
        int n;
        @(negedge clk);
        Number1  = n1;
        Number2  = n2;
        printout = OP_DIV;
        start    = 1;
        @(negedge clk);
        start = 0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("lit_latency",    32'(n),          32'(exp_lat));
        chk("lit_quotient",   32'(quotient),   32'(eq));
        chk("lit_remainder",  32'(remainder),  32'(er));
        chk("lit_balancebit", 32'(balancebit), 32'(eb));
        chk("lit_divzero",    32'(divzero),    32'(edz));
        chk("lit_conclusion", conclusion,      {22'b0, eq});
        @(negedge clk);
    endtask

    initial begin
        int n;
        int base;
        int cyc;
        clk      = 0;
        reset    = 1;
        start    = 0;
        printout = '0;
        Number1  = '0;
        Number2  = '0;

        repeat (2) @(negedge clk);
        chk("lit_reset_busy",     32'(busy),     32'd0);
        chk("lit_reset_quotient", 32'(quotient), 32'd0);
        reset = 0;

        run_div(10'd100,  5'd7,  10, 10'd14,  5'd2, 1'b0, 1'b0);
        chk("lit_conclusion_hex", conclusion, 32'h0000000E);
        run_div(10'd1023, 5'd31, 10, 10'd33,  5'd0, 1'b1, 1'b0);
        run_div(10'd961,  5'd31, 10, 10'd31,  5'd0, 1'b0, 1'b0);
        run_div(10'd3,    5'd5,  10, 10'd0,   5'd3, 1'b1, 1'b0);
        run_div(10'd5,    5'd0,  1,  10'h3FF, 5'd0, 1'b1, 1'b1);

        // Multiply opcode must not start the divider.
        @(negedge clk);
        Number1  = 10'd50;
        Number2  = 5'd3;
        printout = OP_MUL;
        start    = 1;
        @(negedge clk);
        start = 0;
        chk("lit_wrongop_busy",     32'(busy),     32'd0);
        chk("lit_wrongop_quotient", 32'(quotient), 32'h3FF);
        chk("lit_wrongop_divzero",  32'(divzero),  32'd1);
        @(negedge clk);

        // Second request during RUN is dropped; the first answer (200/9) stands.
        Number1  = 10'd200;
        Number2  = 5'd9;
        printout = OP_DIV;
        start    = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        Number1 = 10'd999;
        Number2 = 5'd1;
        start   = 1;
        @(negedge clk);
        start = 0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("lit_busystart_quotient",  32'(quotient),  32'd22);
        chk("lit_busystart_remainder", 32'(remainder), 32'd2);
        repeat (2) @(negedge clk);

        // Reset in the middle of RUN abandons the division.
        Number1 = 10'd500;
        Number2 = 5'd3;
        start   = 1;
        @(negedge clk);
        start = 0;
        repeat (5) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("lit_midreset_busy",      32'(busy),      32'd0);
        chk("lit_midreset_done",      32'(done),      32'd0);
        chk("lit_midreset_quotient",  32'(quotient),  32'd0);
        chk("lit_midreset_remainder", 32'(remainder), 32'd0);
        run_div(10'd500, 5'd3, 10, 10'd166, 5'd2, 1'b1, 1'b0);

        // Random traffic: mixed opcodes, starts at any time, zero divisors and rare resets.
        base = accepted;
        cyc  = 0;
        while ((accepted - base) < 500 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            Number1  = DW'($urandom_range(0, 1023));
            Number2  = ($urandom_range(0, 9) == 0) ? 5'd0 : VW'($urandom_range(1, 31));
            printout = ($urandom_range(0, 5) == 0) ? OP_MUL : OP_DIV;
            start    = ($urandom_range(0, 2) == 0);
            reset    = ($urandom_range(0, 999) == 0);
        end
        chk("random_accept_count", 32'((accepted - base) >= 500), 32'd1);
        start = 0;
        reset = 0;
        repeat (15) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/division_unit.md
Name: division_unit

Overview:
- Sequential unsigned restoring divider for the ALU; the inverse of the multiply path.
- Takes a 10-bit dividend (multiply-product width) and a 5-bit divisor, and produces a 10-bit quotient and a 5-bit remainder.
- Drives the same ALU result bus and balance (even-parity) flag as the other ALU operations.
- Selected by opcode 6'b000101 on the printout bus; shares that bus with the multiply operation.

Parameters:
- DW, 10, dividend and quotient width.
- VW, 5, divisor and remainder width.
- OPCODE, 6'b000101, printout value that selects division.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Number1  input  DW  dividend, unsigned.
- Number2  input  VW  divisor, unsigned.
- printout  input  6  ALU opcode bus.
- start  input  1  request; accepted only when it coincides with printout==OPCODE.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when results become valid.
- divzero  output  1  high when the last accepted divisor was 0.
- quotient  output  DW  result quotient.
- remainder  output  VW  result remainder.
- balancebit  output  1  1 when quotient has an even number of 1s (including zero 1s), else 0.
- conclusion  output  32  {22'b0, quotient}; zero-extended because the operation is unsigned.

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - state=IDLE.
  - busy, done, divzero, balancebit = 0.
  - quotient, remainder, conclusion = 0.
  - Applies mid-operation too: the division in flight is abandoned and no done pulse is produced.
- States:
  - IDLE: waits for an accepted start.
  - RUN: one quotient bit per cycle.
  - FIN: registers results and pulses done.
- Accept condition: start=1, printout==OPCODE and state==IDLE at edge E0. On acceptance:
  - Latch Number1 and Number2 internally.
  - Clear the partial remainder (VW+1 bits) and set the iteration counter to DW-1.
- Divisor nonzero:
  - IDLE->RUN at E0.
  - RUN, edges E1..E10, each edge: shift the partial remainder left, bringing in the next dividend MSB; subtract the divisor; if the result is non-negative, keep it and set quotient bit 1; otherwise restore and set 0.
  - RUN->FIN at E10.
  - FIN registers the outputs; done=1 for the cycle after E10.
  - FIN->IDLE at E11; done returns to 0 there.
- Divisor zero:
  - IDLE->FIN at E0, skipping RUN.
  - Results: quotient=10'h3FF, remainder=0, divzero=1; done=1 for the cycle after E1.
- busy: 1 from the cycle after E0 up to and including the cycle where done=1.
- Output update rule: quotient, remainder, balancebit, conclusion and divzero change only on the edge that raises done. They hold their values until the next completion or reset.
- Ignored starts (no effect on state or outputs):
  - start while busy=1;
  - start with printout!=OPCODE.
- Input stability: Number1, Number2 and printout changing during RUN have no effect, because the operands are latched.
- start in the FIN cycle is ignored; a new start is accepted from IDLE on the following edge.
- Width rules:
  - The partial remainder is VW+1 bits so the subtraction borrow is visible.
  - The final remainder is always < divisor, so it fits in VW bits.
  - The quotient fits in DW bits for any nonzero divisor.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_MUL=6'b000100 and OP_DIV=6'b000101;
  - width constants DW=10 and VW=5;
  - the state enum {IDLE, RUN, FIN}.
- One natural sub-module, even_parity: combinational, input DW bits, output 1 when the count of 1s is even. It is reused by the multiply path for its balancebit.

Test Plan:
- Basic division: reset, then Number1=100, Number2=7, start with printout=000101 -> done exactly 11 edges after accept; quotient=14, remainder=2, conclusion=32'h0000000E, balancebit=0, divzero=0.
- Maximum values: Number1=1023, Number2=31 -> quotient=33, remainder=0, balancebit=1; Number1=961, Number2=31 -> quotient=31, remainder=0, balancebit=0.
- Dividend smaller than divisor, and divisor zero:
  - Number1=3, Number2=5 -> quotient=0, remainder=3, balancebit=1.
  - Number1=5, Number2=0 -> done 2 edges after accept, divzero=1, quotient=10'h3FF, remainder=0, balancebit=1.
- Ignored starts:
  - start with printout=000100 -> busy stays 0, outputs unchanged.
  - Second start at cycle 4 of a running division with different operands -> ignored; first result delivered unchanged.
- Reset mid-operation: reset=1 at cycle 5 of RUN -> next cycle busy=0, all outputs 0, no done pulse; a fresh start immediately afterward completes correctly.
- Randomized check: 500 random operand pairs against a reference model of quotient, remainder and parity; done is high exactly one cycle per accepted start.
